// File: rtl/adc_cap_seq.sv
// ADC capture sequencer: periodic or software triggers drive an active-low start
// strobe, then wait for the ADC's conversion-complete pulse or a timeout.
module adc_cap_seq #(
    parameter int CLK_FREQ      = 20000000,
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] periodTicks,
    input  logic [7:0]  holdTicks,
    input  logic        swTrig,
    input  logic        capDone,
    input  logic        clrErr,
    output logic        startCapture,
    output logic        busy,
    output logic        doneStb,
    output logic [15:0] frameCount,
    output logic        overrun,
    output logic        timeoutErr
);
    typedef enum logic [1:0] {IDLE, HOLD, WAIT} stateT;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_TICKS - 1);

    // CLK_FREQ is informational; the empty block only records a sane configuration.
    if (CLK_FREQ > 0 && TIMEOUT_TICKS > 0) begin : gCfgOk
    end

    stateT       state, nextState;
    logic [31:0] perEff, perCur, perCnt, toCnt;
    logic [7:0]  holdEff, holdCnt;
    logic        enQ, tick, trig, toExpire;
    logic        startD, busyD, doneD, ovrSet, toSet;

    assign perEff  = (periodTicks < 32'd2) ? 32'd2 : periodTicks;
    // First enabled cycle (after enable rise or reset release) starts from a fresh load.
    assign perCur  = enQ ? perCnt : perEff - 32'd1;
    assign tick    = enable && (perCur == '0);
    assign trig    = tick || swTrig;
    assign holdEff = (holdTicks == '0) ? 8'd1 : holdTicks;
    assign toExpire = (toCnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enQ    <= 1'b0;
            perCnt <= '0;
        end else begin
            enQ    <= enable;
            perCnt <= (!enable || tick) ? perEff - 32'd1 : perCur - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Hold count is captured on the edge that enters HOLD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            holdCnt <= '0;
            toCnt   <= '0;
        end else begin
            if (state == IDLE)      holdCnt <= holdEff - 8'd1;
            else if (state == HOLD) holdCnt <= holdCnt - 8'd1;
            toCnt <= (state == WAIT) ? toCnt + 32'd1 : '0;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (trig) nextState = HOLD;
            HOLD:    if (holdCnt == '0) nextState = WAIT;
            WAIT:    if (capDone || toExpire) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        startD = (nextState != HOLD);
        busyD  = (nextState != IDLE);
        doneD  = (state == WAIT) && capDone;
        ovrSet = trig && (state != IDLE);
        // A completion on the expiry cycle wins over the timeout.
        toSet  = (state == WAIT) && toExpire && !capDone;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            startCapture <= 1'b1;
            busy         <= 1'b0;
            doneStb      <= 1'b0;
            frameCount   <= '0;
            overrun      <= 1'b0;
            timeoutErr   <= 1'b0;
        end else begin
            startCapture <= startD;
            busy         <= busyD;
            doneStb      <= doneD;
            frameCount   <= frameCount + 16'(doneD);
            overrun      <= ovrSet | (overrun & ~clrErr);
            timeoutErr   <= toSet | (timeoutErr & ~clrErr);
        end
    end
endmodule

// File: tb/tb_adc_cap_seq.sv
// Randomized scoreboard bench for adc_cap_seq: expected strobes and completions are
// computed from trigger timing and queued; a negedge monitor pops and compares.
module tb_adc_cap_seq;
    localparam int TO = 16;

    logic        clk = 1'b0, reset = 1'b0, enable = 1'b0;
    logic        swTrig = 1'b0, capDone = 1'b0, clrErr = 1'b0;
    logic [31:0] periodTicks = 32'd10;
    logic [7:0]  holdTicks = 8'd0;
    logic        startCapture, busy, doneStb, overrun, timeoutErr;
    logic [15:0] frameCount;

    adc_cap_seq #(.CLK_FREQ(20000000), .TIMEOUT_TICKS(TO)) dut (
        .clk(clk), .reset(reset), .enable(enable), .periodTicks(periodTicks),
        .holdTicks(holdTicks), .swTrig(swTrig), .capDone(capDone), .clrErr(clrErr),
        .startCapture(startCapture), .busy(busy), .doneStb(doneStb),
        .frameCount(frameCount), .overrun(overrun), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { int cyc; int len; } startT;
    typedef struct { int cyc; logic [15:0] cnt; } doneT;
    startT startQ[$];
    doneT  doneQ[$];

    int          nVec = 0, nBad = 0;
    logic [15:0] expCount = '0;
    bit          expOvr = 1'b0, expTo = 1'b0, monEn = 1'b0, prevStart = 1'b1;
    int          fallCyc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: measures each low window of startCapture and every doneStb pulse.
    always @(negedge clk) begin
        startT s;
        doneT  d;
        if (!monEn) prevStart = 1'b1;
        else begin
            if (prevStart && !startCapture) fallCyc = cyc;
            if (!prevStart && startCapture) begin
                check("start_expected", startQ.size() > 0, 1);
                if (startQ.size() > 0) begin
                    s = startQ.pop_front();
                    check("start_cycle", fallCyc, s.cyc);
                    check("start_len", cyc - fallCyc, s.len);
                end
            end
            prevStart = startCapture;
            if (doneStb) begin
                check("done_expected", doneQ.size() > 0, 1);
                if (doneQ.size() > 0) begin
                    d = doneQ.pop_front();
                    check("done_cycle", cyc, d.cyc);
                    check("done_count", frameCount, d.cnt);
                end
            end
        end
    end

    // One software-triggered capture starting in the current (IDLE) cycle.
    // d<0: no capDone, expect timeout. extraAt/clrAt: offsets of a dropped trigger / clrErr.
    task automatic capture(input int h, input int d, input int extraAt, input int clrAt,
                           input bit holdDone);
        int n, hh, last;
        n    = cyc;
        hh   = (h == 0) ? 1 : h;
        last = (d >= 0) ? hh + 1 + d : hh + TO;
        startQ.push_back('{n + 1, hh});
        if (d >= 0) doneQ.push_back('{n + hh + 2 + d, 16'(expCount + 1)});
        for (int k = 0; k <= last; k++) begin
            swTrig    = (k == 0) || (k == extraAt);
            clrErr    = (k == clrAt);
            capDone   = (d >= 0 && k == hh + 1 + d) || (holdDone && k == 1);
            holdTicks = (k == 0) ? 8'(h) : 8'($urandom);
            step();
            if (k + 1 <= last) check("busy_active", busy, 1);
            if (d < 0 && clrAt < 0 && k + 1 == last) check("timeout_early", timeoutErr, expTo);
        end
        swTrig = 1'b0; capDone = 1'b0; clrErr = 1'b0;
        if (d >= 0) expCount = expCount + 16'd1;
        if (clrAt >= 0) begin expOvr = 1'b0; expTo = 1'b0; end
        if (extraAt >= 1) expOvr = 1'b1;
        if (d < 0) expTo = 1'b1;
        check("busy_idle", busy, 0);
        check("frame_count", frameCount, expCount);
        check("overrun", overrun, expOvr);
        check("timeout_err", timeoutErr, expTo);
    endtask

    task automatic clearErr();
        clrErr = 1'b1;
        step();
        clrErr = 1'b0;
        expOvr = 1'b0; expTo = 1'b0;
        check("clr_overrun", overrun, 0);
        check("clr_timeout", timeoutErr, 0);
    endtask

    // Periodic run: enable (and reset release) at cycle e; captures start at e+P*(k+1),
    // capDone arrives two cycles after startCapture returns high.
    task automatic runPeriodic(input int p, input int n, input int h, input bit sw);
        int e, pe, hh, r;
        e  = cyc;
        pe = (p < 2) ? 2 : p;
        hh = (h == 0) ? 1 : h;
        periodTicks = 32'(p);
        holdTicks   = 8'(h);
        for (int k = 0; k < n; k++) begin
            startQ.push_back('{e + pe * (k + 1), hh});
            doneQ.push_back('{e + pe * (k + 1) + hh + 3, 16'(expCount + k + 1)});
        end
        for (int rel = 0; rel <= pe * n + hh + 3; rel++) begin
            reset   = 1'b1;
            enable  = (rel <= pe * n - 1);
            swTrig  = sw && (rel == pe - 1);
            r       = rel - hh - 2;
            capDone = (r >= pe) && (r % pe == 0) && (r / pe <= n);
            step();
        end
        enable = 1'b0; swTrig = 1'b0; capDone = 1'b0;
        expCount = 16'(expCount + n);
        check("periodic_count", frameCount, expCount);
        check("periodic_overrun", overrun, expOvr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run still active, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        check("rst_start", startCapture, 1);
        check("rst_busy", busy, 0);
        check("rst_done", doneStb, 0);
        check("rst_count", frameCount, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeoutErr, 0);
        reset = 1'b1;
        step();
        monEn = 1'b1;

        // Software trigger with hold 0 -> one-cycle strobe.
        capture(0, 3, -1, -1, 1'b0);
        // Periodic triggering, with a coincident swTrig on the first tick; then period<2.
        runPeriodic(10, 4, 3, 1'b1);
        runPeriodic(1, 1, 1, 1'b0);

        // Overrun set, clear, then clear and set in the same cycle.
        capture(3, 2, 2, -1, 1'b0);
        clearErr();
        capture(2, 1, 1, -1, 1'b0);
        capture(2, 1, 2, 2, 1'b0);
        clearErr();

        // Timeout, then completion exactly on the expiry cycle.
        capture(2, -1, -1, -1, 1'b0);
        clearErr();
        capture(2, TO - 1, -1, -1, 1'b0);
        capture(4, 0, -1, -1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            int h, d, hh, last, ex;
            h    = $urandom_range(0, 5);
            hh   = (h == 0) ? 1 : h;
            d    = ($urandom_range(0, 9) == 0) ? -1 :
                   (($urandom_range(0, 6) == 0) ? TO - 1 : int'($urandom_range(0, 3)));
            last = (d >= 0) ? hh + 1 + d : hh + TO;
            ex   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, last)) : -1;
            capture(h, d, ex, ($urandom_range(0, 4) == 0) ? ex : -1, 1'($urandom_range(0, 1)));
            if ((expOvr || expTo) && $urandom_range(0, 1) == 1) clearErr();
            repeat ($urandom_range(0, 2)) begin
                capDone = 1'($urandom_range(0, 1));
                step();
            end
            capDone = 1'b0;
        end

        // Reset in the middle of HOLD.
        holdTicks = 8'd5;
        swTrig = 1'b1;
        step();
        swTrig = 1'b0;
        check("rst_mid_hold", startCapture, 0);
        monEn = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_async_start", startCapture, 1);
        check("rst_async_busy", busy, 0);
        check("rst_async_count", frameCount, 0);
        check("rst_async_overrun", overrun, 0);
        expCount = '0; expOvr = 1'b0; expTo = 1'b0;
        startQ.delete(); doneQ.delete();
        enable = 1'b1; periodTicks = 32'd7; holdTicks = 8'd2;
        for (int i = 0; i < 4; i++) begin
            capDone = 1'b1;
            @(negedge clk);
            check("rst_no_done", doneStb, 0);
            check("rst_hold_start", startCapture, 1);
            step();
        end
        capDone = 1'b0;
        monEn = 1'b1;
        runPeriodic(7, 2, 2, 1'b0);

        // Counter wrap from 0xFFFF.
        force dut.frameCount = 16'hFFFF;
        step();
        release dut.frameCount;
        expCount = 16'hFFFF;
        check("wrap_preload", frameCount, 16'hFFFF);
        capture(1, 0, -1, -1, 1'b0);

        repeat (3) step();
        check("startq_drained", startQ.size(), 0);
        check("doneq_drained", doneQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end
endmodule

// File: doc/adc_cap_seq.md
ADC_CAP_SEQ -- requirements
Module: adc_cap_seq

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  CLK_FREQ  20000000  clock frequency in Hz, informational only
  TIMEOUT_TICKS  4096  maximum cycles spent in WAIT before abort
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all logic on the rising edge
  reset  in  1  asynchronous, active-low reset
  enable  in  1  1 = periodic triggering runs
  periodTicks  in  32  cycles between periodic triggers
  holdTicks  in  8  cycles startCapture is held low
  swTrig  in  1  one-cycle software trigger request
  capDone  in  1  one-cycle pulse from the ADC: conversion complete
  clrErr  in  1  one-cycle pulse: clears the sticky error flags
  startCapture  out  1  active-low start strobe to the ADC
  busy  out  1  1 whenever the state is not IDLE
  doneStb  out  1  one-cycle pulse when a capture completes
  frameCount  out  16  count of completed captures
  overrun  out  1  sticky flag: a trigger was dropped
  timeoutErr  out  1  sticky flag: capDone never arrived

Function
REQ-003 The state machine SHALL have three states: IDLE, HOLD and WAIT.
REQ-004 The period counter SHALL work as follows.
  - While enable=0 it loads periodTicks-1.
  - While enable=1 it decrements each cycle.
  - At 0 it asserts an internal tick for one cycle and reloads periodTicks-1.
REQ-005 A periodTicks value below 2 SHALL be treated as 2.
REQ-006 The first periodic tick SHALL occur exactly periodTicks cycles after enable rises.
REQ-007 A trigger is a tick or swTrig=1. A trigger sampled in IDLE at cycle N SHALL move the FSM to HOLD, with startCapture=0 from cycle N+1.
REQ-008 A tick and swTrig in the same IDLE cycle SHALL start exactly one capture and SHALL NOT set overrun.
REQ-009 A trigger sampled while in HOLD or WAIT SHALL be dropped and SHALL set overrun.
REQ-010 holdTicks SHALL be latched on entry to HOLD; a value of 0 SHALL be treated as 1.
REQ-011 startCapture SHALL stay 0 for exactly the latched hold count of cycles, after which it returns to 1 and the FSM enters WAIT.
REQ-012 capDone asserted while in HOLD or IDLE SHALL be ignored.
REQ-013 capDone sampled in WAIT SHALL, on the next edge:
  - return the FSM to IDLE;
  - pulse doneStb for one cycle;
  - increment frameCount modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-014 In WAIT, the timeout counter SHALL count cycles; after TIMEOUT_TICKS cycles without capDone the FSM SHALL:
  - return to IDLE;
  - set timeoutErr;
  - leave frameCount and doneStb unchanged.
REQ-015 If capDone arrives in the same cycle the timeout expires, the capture SHALL count as complete and timeoutErr SHALL NOT be set.
REQ-016 clrErr SHALL clear overrun and timeoutErr; if a set event occurs in the same cycle, the set SHALL win.
REQ-017 A new trigger SHALL be accepted in the first IDLE cycle after completion or timeout (no dead cycle).
REQ-018 Changes to periodTicks SHALL take effect at the next reload; changes to holdTicks SHALL take effect at the next HOLD entry.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 While reset=0 the block SHALL asynchronously force:
  - FSM to IDLE;
  - startCapture=1, busy=0, doneStb=0;
  - frameCount=0, overrun=0, timeoutErr=0;
  - period counter to periodTicks-1.
REQ-021 A reset asserted mid-capture SHALL abort the capture immediately, with startCapture back at 1 and no doneStb.
REQ-022 After reset deasserts, the block SHALL behave as if enable had just risen.

Verification
REQ-023 Periodic triggering: enable=1, periodTicks=10, holdTicks=3, capDone 2 cycles after startCapture rises.
  - startCapture is low for 3 cycles every 10 cycles.
  - frameCount increments per capture.
  - doneStb is 1 cycle wide.
REQ-024 Software trigger: enable=0, swTrig at cycle N, holdTicks=0.
  - startCapture=0 only in cycle N+1.
  - busy=1 from N+1 until capDone is accepted.
REQ-025 Overrun: trigger issued, then a second swTrig during HOLD.
  - overrun=1, only one capture occurs.
  - clrErr then clears overrun.
  - Check clrErr together with a new overrun: overrun stays 1.
REQ-026 Timeout: TIMEOUT_TICKS=16, capDone never asserted.
  - timeoutErr=1 exactly 16 cycles after WAIT entry.
  - FSM returns to IDLE, frameCount unchanged.
  - Repeat with capDone on the expiry cycle: frameCount+1, timeoutErr=0.
REQ-027 Wrap: preload 0xFFFF completions.
  - Next capDone gives frameCount=0x0000 and doneStb=1.
REQ-028 Reset mid-capture: reset=0 during HOLD.
  - startCapture=1 asynchronously, frameCount=0, no doneStb.
  - First tick arrives periodTicks cycles after release.
